// File: rtl/vsdminisoc_pkg.sv
// ----------------------------------------------------------------------------
// vsdminisoc_pkg
// Shared constants for the mini-SoC sample path between the rvmyth core's
// 10-bit output and the avsddac D input. Used by dac_sample_pacer and by the
// top-level DAC hookup so both agree on sample width and mid-rail code.
// No ports (package).
// ----------------------------------------------------------------------------
package vsdminisoc_pkg;

    // Width of a core sample and of the DAC D input.
    localparam int unsigned SAMPLE_W = 10;

    // DAC mid-rail code, (VREFH+VREFL)/2; the DAC parks here out of reset.
    localparam logic [SAMPLE_W-1:0] DAC_MIDSCALE = 10'd512;

    typedef logic [SAMPLE_W-1:0] sample_t;

endpackage : vsdminisoc_pkg

// File: rtl/dac_sample_fifo.sv
// ----------------------------------------------------------------------------
// dac_sample_fifo
// Small synchronous FIFO buffering core samples ahead of the DAC pacer.
// Head is presented combinationally on rdata. Full/empty come from registered
// flags computed from the next occupancy, so they carry no combinational path
// from push/pop.
// Ports:
//   clk    in   clock
//   rst_n  in   asynchronous active-low reset; empties the FIFO
//   push   in   write wdata (ignored while full)
//   pop    in   drop the head (ignored while empty)
//   wdata  in   DATA_W  write data
//   rdata  out  DATA_W  current head
//   level  out  occupancy, 0..DEPTH
//   full   out  level == DEPTH
//   empty  out  level == 0
// ----------------------------------------------------------------------------
module dac_sample_fifo
    import vsdminisoc_pkg::*;
#(
    parameter int unsigned DATA_W = SAMPLE_W,
    parameter int unsigned DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        rdata,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q,  level_d;
    logic             full_q,   full_d;
    logic             empty_q,  empty_d;
    logic             push_ok;
    logic             pop_ok;

    // Guard against overflow/underflow regardless of what the caller does.
    assign push_ok = push && !full_q;
    assign pop_ok  = pop && !empty_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;

        // Pointers are PTR_W bits and DEPTH is a power of two, so +1 wraps.
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        unique case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase

        full_d  = (level_d == LVL_W'(DEPTH));
        empty_d = (level_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage needs no reset: occupancy tracking masks stale entries.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign level = level_q;
    assign full  = full_q;
    assign empty = empty_q;

endmodule : dac_sample_fifo

// File: rtl/dac_sample_pacer.sv
// ----------------------------------------------------------------------------
// dac_sample_pacer
// Rate-controlled sample feeder from the core to the DAC D input. Bursty core
// writes are buffered in dac_sample_fifo; a divider releases one sample to the
// DAC every (div+1) CLK cycles. A release tick that finds the FIFO empty leaves
// dac_d unchanged and sets the sticky underrun flag.
// Ports:
//   CLK          in   system clock
//   reset_n      in   asynchronous active-low reset
//   enable       in   1 = pacing runs; 0 = divider held in reload
//   div          in   DIV_W   tick period minus 1
//   in_data      in   DATA_W  sample from core
//   in_valid     in   in_data valid
//   in_ready     out  FIFO can accept (not full)
//   dac_d        out  DATA_W  registered sample to the DAC
//   sample_stb   out  1-cycle pulse while dac_d shows a newly released sample
//   underrun     out  sticky empty-at-tick flag
//   clr_underrun in   synchronous clear of underrun (a same-cycle set wins)
//   level        out  FIFO occupancy
// ----------------------------------------------------------------------------
module dac_sample_pacer
    import vsdminisoc_pkg::*;
#(
    parameter int unsigned DATA_W   = SAMPLE_W,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned DIV_W    = 16,
    parameter int unsigned MIDSCALE = int'(DAC_MIDSCALE)
) (
    input  logic                   CLK,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic [DIV_W-1:0]       div,
    input  logic [DATA_W-1:0]      in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [DATA_W-1:0]      dac_d,
    output logic                   sample_stb,
    output logic                   underrun,
    input  logic                   clr_underrun,
    output logic [$clog2(DEPTH):0] level
);

    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic [DIV_W-1:0]  cnt_eff;
    logic              reload_q, reload_d;
    logic              tick;

    logic [DATA_W-1:0] dac_d_q, dac_d_d;
    logic              stb_q, stb_d;
    logic              underrun_q, underrun_d;

    logic              fifo_push;
    logic              fifo_pop;
    logic [DATA_W-1:0] fifo_rdata;
    logic              fifo_full;
    logic              fifo_empty;

    // ------------------------------------------------------------------
    // Rate divider. reload_q marks a counter that has not been loaded yet
    // (after reset); it then behaves as if it already held div, so the
    // first tick is div+1 cycles into enabled operation.
    // ------------------------------------------------------------------
    always_comb begin
        cnt_eff  = reload_q ? div : cnt_q;
        cnt_d    = cnt_q;
        reload_d = reload_q;
        tick     = 1'b0;

        if (!enable) begin
            cnt_d    = div;
            reload_d = 1'b0;
        end else begin
            reload_d = 1'b0;
            if (cnt_eff == '0) begin
                tick  = 1'b1;
                cnt_d = div;
            end else begin
                cnt_d = cnt_eff - DIV_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Release path. Empty is the registered flag, so a push landing in
    // the same cycle as an empty tick is stored, never bypassed.
    // ------------------------------------------------------------------
    assign fifo_push = in_valid && !fifo_full;
    assign fifo_pop  = tick && !fifo_empty;

    always_comb begin
        dac_d_d    = dac_d_q;
        stb_d      = fifo_pop;
        underrun_d = underrun_q;

        if (fifo_pop) begin
            dac_d_d = fifo_rdata;
        end

        if (tick && fifo_empty) begin
            underrun_d = 1'b1;
        end else if (clr_underrun) begin
            underrun_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q      <= '0;
            reload_q   <= 1'b1;
            dac_d_q    <= DATA_W'(MIDSCALE);
            stb_q      <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            reload_q   <= reload_d;
            dac_d_q    <= dac_d_d;
            stb_q      <= stb_d;
            underrun_q <= underrun_d;
        end
    end

    dac_sample_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst_n (reset_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (in_data),
        .rdata (fifo_rdata),
        .level (level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign in_ready   = !fifo_full;
    assign dac_d      = dac_d_q;
    assign sample_stb = stb_q;
    assign underrun   = underrun_q;

endmodule : dac_sample_pacer

// File: tb/tb_dac_sample_pacer.sv
// ----------------------------------------------------------------------------
// tb_dac_sample_pacer
// Self-checking bench for dac_sample_pacer. A behavioural model (sample queue,
// divider, output registers) is advanced alongside the stimulus; expected
// samples are pushed when the core-side write is accepted and popped at
// release ticks. Scenario tasks also check the fixed timings directly.
// ----------------------------------------------------------------------------
module tb_dac_sample_pacer;

    logic        CLK;
    logic        reset_n;
    logic        enable;
    logic [15:0] div;
    logic [9:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [9:0]  dac_d;
    logic        sample_stb;
    logic        underrun;
    logic        clr_underrun;
    logic [3:0]  level;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state
    logic [9:0] m_q [$];
    int         m_cnt;
    logic       m_reload;
    logic [9:0] m_dac;
    logic       m_stb;
    logic       m_unr;

    dac_sample_pacer u_dut (
        .CLK          (CLK),
        .reset_n      (reset_n),
        .enable       (enable),
        .div          (div),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .dac_d        (dac_d),
        .sample_stb   (sample_stb),
        .underrun     (underrun),
        .clr_underrun (clr_underrun),
        .level        (level)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic mdl_reset();
        m_q.delete();
        m_cnt    = 0;
        m_reload = 1'b1;
        m_dac    = 10'd512;
        m_stb    = 1'b0;
        m_unr    = 1'b0;
    endtask

    task automatic idle_inputs();
        enable       = 1'b0;
        div          = 16'd0;
        in_data      = 10'd0;
        in_valid     = 1'b0;
        clr_underrun = 1'b0;
    endtask

    // Called just after a falling edge: drive inputs, advance the model over
    // the coming rising edge, return at the next falling edge.
    task automatic step(input logic v, input logic [9:0] d, input logic e,
                        input logic [15:0] dv, input logic c);
        int   eff;
        logic tk;
        logic was_empty;
        logic acc;
        in_valid     = v;
        in_data      = d;
        enable       = e;
        div          = dv;
        clr_underrun = c;
        acc       = v && (m_q.size() < 8);
        was_empty = (m_q.size() == 0);
        tk        = 1'b0;
        if (!e) begin
            m_cnt    = int'(dv);
            m_reload = 1'b0;
        end else begin
            eff      = m_reload ? int'(dv) : m_cnt;
            m_reload = 1'b0;
            tk       = (eff == 0);
            m_cnt    = tk ? int'(dv) : eff - 1;
        end
        m_stb = tk && !was_empty;
        if (m_stb) m_dac = m_q.pop_front();
        if (tk && was_empty) m_unr = 1'b1;
        else if (c) m_unr = 1'b0;
        if (acc) m_q.push_back(d);
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        idle_inputs();
        mdl_reset();
        repeat (3) @(negedge CLK);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (dac_d !== 10'd512) begin
            n_bad++; $display("FAIL reset_dac_d got=%0d exp=512", dac_d);
        end
        n_cmp++;
        if (level !== 4'd0) begin
            n_bad++; $display("FAIL reset_level got=%0d exp=0", level);
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready);
        end
        n_cmp++;
        if (underrun !== 1'b0) begin
            n_bad++; $display("FAIL reset_underrun got=%b exp=0", underrun);
        end
        n_cmp++;
        if (sample_stb !== 1'b0) begin
            n_bad++; $display("FAIL reset_stb got=%b exp=0", sample_stb);
        end
    endtask

    task automatic test_pacing();
        logic [9:0] got [$];
        int         idx [$];
        int         exp_idx [3] = '{3, 7, 11};
        logic [9:0] exp_val [3] = '{10'h010, 10'h020, 10'h030};
        do_reset();
        for (int i = 0; i < 16; i++) begin
            step(i < 3, 10'(16 * (i + 1)), 1'b1, 16'd3, 1'b0);
            n_cmp++;
            if (dac_d !== m_dac || sample_stb !== m_stb || level !== 4'(m_q.size())) begin
                n_bad++;
                $display("FAIL pacing_cyc%0d got dac=%h stb=%b lvl=%0d exp dac=%h stb=%b lvl=%0d",
                         i, dac_d, sample_stb, level, m_dac, m_stb, m_q.size());
            end
            if (sample_stb === 1'b1) begin
                got.push_back(dac_d);
                idx.push_back(i);
            end
        end
        n_cmp++;
        if (got.size() != 3) begin
            n_bad++; $display("FAIL pacing_count got=%0d exp=3", got.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (got[k] !== exp_val[k] || idx[k] != exp_idx[k]) begin
                    n_bad++;
                    $display("FAIL pacing_step%0d got val=%h cyc=%0d exp val=%h cyc=%0d",
                             k, got[k], idx[k], exp_val[k], exp_idx[k]);
                end
            end
        end
    endtask

    task automatic test_full();
        logic [9:0] got [$];
        int         idx [$];
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 10'(i + 1), 1'b0, 16'd0, 1'b0);
            n_cmp++;
            if (in_ready !== (i < 7) || level !== 4'(m_q.size())) begin
                n_bad++;
                $display("FAIL full_fill%0d got rdy=%b lvl=%0d exp rdy=%b lvl=%0d",
                         i, in_ready, level, (i < 7), m_q.size());
            end
        end
        n_cmp++;
        if (level !== 4'd8) begin
            n_bad++; $display("FAIL full_level got=%0d exp=8", level);
        end
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 10'd0, 1'b1, 16'd0, 1'b0);
            n_cmp++;
            if (dac_d !== m_dac || sample_stb !== m_stb || underrun !== m_unr) begin
                n_bad++;
                $display("FAIL full_drain%0d got dac=%0d stb=%b unr=%b exp dac=%0d stb=%b unr=%b",
                         i, dac_d, sample_stb, underrun, m_dac, m_stb, m_unr);
            end
            if (sample_stb === 1'b1) begin
                got.push_back(dac_d);
                idx.push_back(i);
            end
        end
        n_cmp++;
        if (got.size() != 8) begin
            n_bad++; $display("FAIL full_count got=%0d exp=8", got.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                n_cmp++;
                if (got[k] !== 10'(k + 1) || idx[k] != k) begin
                    n_bad++;
                    $display("FAIL full_out%0d got val=%0d cyc=%0d exp val=%0d cyc=%0d",
                             k, got[k], idx[k], k + 1, k);
                end
            end
        end
    endtask

    task automatic test_underrun();
        logic exp_u [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            // Tick falls on step 5 (clear must lose); step 6 is not a tick.
            step(1'b0, 10'd0, 1'b1, 16'd2, (i >= 5));
            n_cmp++;
            if (underrun !== exp_u[i] || underrun !== m_unr || dac_d !== 10'd512) begin
                n_bad++;
                $display("FAIL underrun_cyc%0d got unr=%b dac=%0d exp unr=%b dac=512",
                         i, underrun, dac_d, exp_u[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] got [$];
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 10'(100 + i), 1'b0, 16'd0, 1'b0);
        end
        for (int i = 0; i < 26; i++) begin
            step(i < 20, 10'(104 + i), 1'b1, 16'd0, 1'b0);
            if (i < 20) begin
                n_cmp++;
                if (level !== 4'd4) begin
                    n_bad++; $display("FAIL b2b_level%0d got=%0d exp=4", i, level);
                end
            end
            n_cmp++;
            if (dac_d !== m_dac || sample_stb !== m_stb) begin
                n_bad++;
                $display("FAIL b2b_cyc%0d got dac=%0d stb=%b exp dac=%0d stb=%b",
                         i, dac_d, sample_stb, m_dac, m_stb);
            end
            if (sample_stb === 1'b1) got.push_back(dac_d);
        end
        n_cmp++;
        if (got.size() != 24) begin
            n_bad++; $display("FAIL b2b_count got=%0d exp=24", got.size());
        end else begin
            for (int k = 0; k < 24; k++) begin
                if (got[k] !== 10'(100 + k)) begin
                    n_cmp++; n_bad++;
                    $display("FAIL b2b_order%0d got=%0d exp=%0d", k, got[k], 100 + k);
                end else begin
                    n_cmp++;
                end
            end
        end
    endtask

    task automatic test_midrun_reset();
        int first = -1;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 10'(200 + i), 1'b0, 16'd7, 1'b0);
        end
        n_cmp++;
        if (level !== 4'd5) begin
            n_bad++; $display("FAIL midrst_prelevel got=%0d exp=5", level);
        end
        #2 reset_n = 1'b0;
        idle_inputs();
        mdl_reset();
        #1;
        n_cmp++;
        if (dac_d !== 10'd512 || level !== 4'd0) begin
            n_bad++;
            $display("FAIL midrst_async got dac=%0d lvl=%0d exp dac=512 lvl=0", dac_d, level);
        end
        repeat (2) @(negedge CLK);
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(i == 0, 10'h155, 1'b1, 16'd7, 1'b0);
            if (sample_stb === 1'b1 && first < 0) begin
                first = i;
                n_cmp++;
                if (dac_d !== 10'h155) begin
                    n_bad++; $display("FAIL midrst_data got=%h exp=155", dac_d);
                end
            end
        end
        n_cmp++;
        if (first != 7) begin
            n_bad++; $display("FAIL midrst_latency got=%0d exp=7", first);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        idle_inputs();
        mdl_reset();
        @(negedge CLK);
        test_reset();
        test_pacing();
        test_full();
        test_underrun();
        test_back_to_back();
        test_midrun_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_dac_sample_pacer
